// File: rtl/move_commit_ctrl.sv
// Move commit controller: validates and commits stones to the board memory.
// Ports: move handshake, clear request, single-port board RAM, status outputs.
module move_commit_ctrl #(
    parameter int BOARD_W = 15,
    parameter int BOARD_H = 15,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    input  logic [3:0]        move_x,
    input  logic [3:0]        move_y,
    output logic              move_ready,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [1:0]        mem_wr_data,
    output logic [1:0]        cur_player,
    output logic              move_done,
    output logic              move_reject,
    output logic [ADDR_W-1:0] move_count,
    output logic              board_full,
    output logic              busy
);

    localparam int CELLS = BOARD_W * BOARD_H;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [4:0]        W5      = 5'(BOARD_W);
    localparam logic [4:0]        H5      = 5'(BOARD_H);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_REJECT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep;
    logic [3:0]        x_q;
    logic [3:0]        y_q;
    logic [1:0]        player;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] cell_addr;
    logic              in_range;

    assign in_range  = ({1'b0, move_x} < W5) && ({1'b0, move_y} < H5);
    assign cell_addr = ADDR_W'(y_q) * ADDR_W'(BOARD_W) + ADDR_W'(x_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_CLEAR;
            sweep  <= '0;
            player <= 2'b01;
            count  <= '0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    if (sweep == LAST) begin
                        state  <= S_IDLE;
                        player <= 2'b01;
                        count  <= '0;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                S_IDLE: begin
                    // A clear request wins over a simultaneous move.
                    if (clear_req) begin
                        state <= S_CLEAR;
                        sweep <= '0;
                    end else if (move_valid) begin
                        x_q   <= move_x;
                        y_q   <= move_y;
                        state <= in_range ? S_READ : S_REJECT;
                    end
                end
                S_READ: state <= S_CHECK;
                S_CHECK: begin
                    // Any non-empty code, including 11, blocks the move.
                    state <= (mem_rd_data == 2'b00) ? S_WRITE : S_REJECT;
                end
                S_WRITE: begin
                    player <= ~player;
                    if (count != CELLS_A)
                        count <= count + 1'b1;
                    state <= S_IDLE;
                end
                S_REJECT: state <= S_IDLE;
                default:  state <= S_CLEAR;
            endcase
        end
    end

    assign move_ready  = (state == S_IDLE) && !clear_req;
    assign mem_wr_en   = (state == S_CLEAR) || (state == S_WRITE);
    assign mem_wr_data = (state == S_WRITE) ? player : 2'b00;
    assign mem_addr    = (state == S_CLEAR) ? sweep :
                         ((state == S_READ) || (state == S_CHECK) ||
                          (state == S_WRITE)) ? cell_addr : '0;
    assign move_done   = (state == S_WRITE);
    assign move_reject = (state == S_REJECT);
    assign cur_player  = player;
    assign move_count  = count;
    assign board_full  = (count == CELLS_A);
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Bench for move_commit_ctrl: board RAM model, reference model, scoreboard.
// Stimulus pushes expected pulses; a negedge monitor pops and compares.
module tb_move_commit_ctrl;

    localparam int W = 15;
    localparam int H = 15;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic [3:0] move_x;
    logic [3:0] move_y;
    logic       move_ready;
    logic       clear_req;
    logic [7:0] mem_addr;
    logic [1:0] mem_rd_data;
    logic       mem_wr_en;
    logic [1:0] mem_wr_data;
    logic [1:0] cur_player;
    logic       move_done;
    logic       move_reject;
    logic [7:0] move_count;
    logic       board_full;
    logic       busy;

    move_commit_ctrl #(.BOARD_W(W), .BOARD_H(H), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .move_valid(move_valid), .move_x(move_x), .move_y(move_y),
        .move_ready(move_ready), .clear_req(clear_req),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .cur_player(cur_player), .move_done(move_done),
        .move_reject(move_reject), .move_count(move_count),
        .board_full(board_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM: one-cycle read latency, optional corruption injection.
    logic [1:0] mem [0:255];
    logic       inj_en = 1'b0;
    logic [7:0] inj_addr = 8'd0;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (inj_en) mem[inj_addr] <= 2'b11;
        mem_rd_data <= mem[mem_addr];
    end

    typedef struct {
        logic       done;
        int         at;
        int         addr;
        int         data;
        int         cnt;
    } exp_t;

    exp_t sbq[$];

    logic [1:0] ref_board [0:255];
    int ref_player;
    int ref_count;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (move_done || move_reject)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0d reject=%0d at %0d",
                         move_done, move_reject, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pulse_kind", int'(move_done), int'(e.done));
                chk("pulse_both", int'(move_done & move_reject), 0);
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_wr_en", int'(mem_wr_en), int'(e.done));
                chk("pulse_count", int'(move_count), e.cnt);
                if (e.done) begin
                    chk("wr_addr", int'(mem_addr), e.addr);
                    chk("wr_data", int'(mem_wr_data), e.data);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_board[i] = 2'b00;
        ref_player = 1;
        ref_count  = 0;
    endtask

    task automatic check_idle_status(input string tag);
        chk({tag, "_ready"}, int'(move_ready), 1);
        chk({tag, "_player"}, int'(cur_player), ref_player);
        chk({tag, "_count"}, int'(move_count), ref_count);
        chk({tag, "_full"}, int'(board_full), int'(ref_count == N));
    endtask

    // Called just after the edge that enters the clear sweep.
    task automatic do_sweep();
        int n;
        int ok;
        n  = 0;
        ok = 1;
        @(negedge clk);
        while (busy && n < 300) begin
            if (!(mem_wr_en && int'(mem_addr) == n &&
                  mem_wr_data == 2'b00 && !move_ready))
                ok = 0;
            n++;
            @(negedge clk);
        end
        chk("sweep_len", n, N);
        chk("sweep_writes", ok, 1);
        model_clear();
        check_idle_status("post_clear");
    endtask

    task automatic do_move(input int x, input int y);
        exp_t e;
        int   t;
        int   lat;
        int   k;
        int   a;
        int   stray;
        @(posedge clk);
        #1;
        move_valid = 1'b1;
        move_x     = 4'(x);
        move_y     = 4'(y);
        @(negedge clk);
        k = 0;
        while (!move_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!move_ready) begin
            chk("handshake_timeout", 0, 1);
            move_valid = 1'b0;
            return;
        end
        t     = cyc;
        e.cnt = ref_count;
        e.addr = 0;
        e.data = 0;
        if (x >= W || y >= H) begin
            e.done = 1'b0;
            lat    = 1;
        end else begin
            a   = y * W + x;
            lat = 3;
            if (ref_board[a] != 2'b00) begin
                e.done = 1'b0;
            end else begin
                e.done       = 1'b1;
                e.addr       = a;
                e.data       = ref_player;
                ref_board[a] = 2'(ref_player);
                ref_player   = (ref_player == 1) ? 2 : 1;
                if (ref_count < N) ref_count++;
            end
        end
        e.at = t + lat;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        k     = 0;
        stray = 0;
        do begin
            @(negedge clk);
            if (mem_wr_en && !move_done) stray = 1;
            k++;
        end while (busy && k < 50);
        chk("idle_cycle", cyc, t + lat + 1);
        chk("stray_write", stray, 0);
        check_idle_status("post_move");
    endtask

    task automatic inject(input int a);
        @(posedge clk);
        #1;
        inj_en   = 1'b1;
        inj_addr = 8'(a);
        @(posedge clk);
        #1;
        inj_en = 1'b0;
        ref_board[a] = 2'b11;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int perm [0:N-1];
        int j;
        int tmp;
        reset      = 1'b1;
        move_valid = 1'b0;
        clear_req  = 1'b0;
        move_x     = 4'd0;
        move_y     = 4'd0;
        model_clear();

        @(posedge clk);
        #1;
        reset = 1'b0;
        do_sweep();

        do_move(3, 2);
        do_move(3, 2);
        do_move(15, 0);
        do_move(0, 15);
        inject(5 * W + 5);
        do_move(5, 5);

        for (int i = 0; i < 40; i++)
            do_move($urandom_range(0, 15), $urandom_range(0, 15));

        // Clear and move together: clear wins, the move is dropped.
        @(posedge clk);
        #1;
        clear_req  = 1'b1;
        move_valid = 1'b1;
        move_x     = 4'd1;
        move_y     = 4'd1;
        @(negedge clk);
        chk("ready_during_clear_req", int'(move_ready), 0);
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        move_valid = 1'b0;
        do_sweep();

        // Reset while the controller is in CHECK.
        do_move(7, 7);
        @(posedge clk);
        #1;
        move_valid = 1'b1;
        move_x     = 4'd4;
        move_y     = 4'd4;
        @(negedge clk);
        chk("ready_before_reset_move", int'(move_ready), 1);
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_sweep();

        // Fill the board in random order with random moves mixed in.
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j       = $urandom_range(0, i);
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_move($urandom_range(0, 15), $urandom_range(0, 15));
            do_move(perm[i] % W, perm[i] / W);
        end
        chk("full_count", int'(move_count), N);
        chk("full_flag", int'(board_full), 1);
        chk("full_player", int'(cur_player), 2);
        do_move(0, 0);
        do_move(14, 14);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
